// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_ctrl
// Purpose  : Steps an 8:1 mux select through enabled channels, samples each
//            after a dwell period and assembles the samples into one word.
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl #(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic [7:0] mask,
    input  logic       mux_out,
    output logic [2:0] sel,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] C_DWELL_LAST = 4'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] data_q, data_d;
    logic [3:0] dwell_q, dwell_d;

    logic [2:0] w_first_sel;
    logic [2:0] w_next_sel;
    logic       w_has_next;

    // Lowest enabled channel of the live mask, used whenever a scan is latched.
    always_comb begin
        w_first_sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) w_first_sel = 3'(i);
        end
    end

    // Next enabled channel strictly above the current select.
    always_comb begin
        w_next_sel = 3'd0;
        w_has_next = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (3'(i) > sel_q)) begin
                w_next_sel = 3'(i);
                w_has_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        dwell_d  = dwell_q;
        case (state_q)
            IDLE: begin
                if (start && (mask != 8'd0)) begin
                    mask_d   = mask;
                    shadow_d = 8'd0;
                    sel_d    = w_first_sel;
                    dwell_d  = 4'd0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (dwell_q == C_DWELL_LAST) begin
                    shadow_d[sel_q] = mux_out;
                    dwell_d         = 4'd0;
                    if (w_has_next) begin
                        sel_d = w_next_sel;
                    end else begin
                        // Publish the word including the sample just taken.
                        data_d  = shadow_d;
                        state_d = DONE;
                    end
                end else begin
                    dwell_d = dwell_q + 4'd1;
                end
            end
            DONE: begin
                if (cont && (mask != 8'd0)) begin
                    mask_d   = mask;
                    shadow_d = 8'd0;
                    sel_d    = w_first_sel;
                    dwell_d  = 4'd0;
                    state_d  = SCAN;
                end else begin
                    sel_d   = 3'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                sel_d   = 3'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 3'd0;
            mask_q   <= 8'd0;
            shadow_q <= 8'd0;
            data_q   <= 8'd0;
            dwell_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            dwell_q  <= dwell_d;
        end
    end

    assign sel      = sel_q;
    assign data_out = data_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan_ctrl
// Purpose  : Directed self-checking bench for mux_scan_ctrl (DWELL = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

    localparam int DWELL = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic       cont;
    logic [7:0] mask;
    logic       mux_out;
    logic [2:0] sel;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic [7:0] pat;

    int n_cmp;
    int n_err;

    mux_scan_ctrl #(.DWELL(DWELL)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cont     (cont),
        .mask     (mask),
        .mux_out  (mux_out),
        .sel      (sel),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    // The mux model: output is the pattern bit addressed by the select.
    assign mux_out = pat[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One single-shot scan; expected select sequence derived from the mask.
    task automatic run_scan(input logic [7:0] m, input logic [7:0] p, input bit hold_start);
        logic [7:0] exp_data;
        logic [2:0] last;
        exp_data = m & p;
        last     = 3'd0;
        @(negedge clk);
        mask  = m;
        pat   = p;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        mask = ~m;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                last = 3'(i);
                for (int d = 0; d < DWELL; d++) begin
                    @(negedge clk);
                    check_val("scan_sel", {29'd0, sel}, i);
                    check_val("scan_busy", {31'd0, busy}, 1);
                    check_val("scan_done", {31'd0, done}, 0);
                end
            end
        end
        @(negedge clk);
        check_val("done_strobe", {31'd0, done}, 1);
        check_val("done_busy", {31'd0, busy}, 1);
        check_val("done_sel", {29'd0, sel}, {29'd0, last});
        check_val("done_data", {24'd0, data_out}, {24'd0, exp_data});
        start = 1'b0;
        @(negedge clk);
        check_val("idle_done", {31'd0, done}, 0);
        check_val("idle_busy", {31'd0, busy}, 0);
        check_val("idle_sel", {29'd0, sel}, 0);
        check_val("idle_data_hold", {24'd0, data_out}, {24'd0, exp_data});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        mask  = 8'd0;
        pat   = 8'd0;

        // Asynchronous reset with no clock edge.
        #2 rst = 1'b1;
        #1;
        check_val("rst_sel", {29'd0, sel}, 0);
        check_val("rst_data", {24'd0, data_out}, 0);
        check_val("rst_busy", {31'd0, busy}, 0);
        check_val("rst_done", {31'd0, done}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_scan(8'hFF, 8'hA5, 1'b0);
        run_scan(8'h91, 8'hFF, 1'b0);
        // start held high through the scan must not disturb it.
        run_scan(8'h3C, 8'h55, 1'b1);

        // start with an empty mask is ignored.
        @(negedge clk);
        mask  = 8'h00;
        start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_val("zmask_busy", {31'd0, busy}, 0);
            check_val("zmask_done", {31'd0, done}, 0);
        end
        start = 1'b0;

        // Abort mid-scan with reset.
        @(negedge clk);
        mask  = 8'hFF;
        pat   = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("abort_sel", {29'd0, sel}, 0);
        check_val("abort_data", {24'd0, data_out}, 0);
        check_val("abort_busy", {31'd0, busy}, 0);
        check_val("abort_done", {31'd0, done}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_val("post_abort_busy", {31'd0, busy}, 0);
            check_val("post_abort_done", {31'd0, done}, 0);
        end

        // Continuous mode: two words, period N*DWELL+1 = 5.
        @(negedge clk);
        mask  = 8'h03;
        pat   = 8'h01;
        cont  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            logic [2:0] exp_sel;
            logic [7:0] exp_data;
            @(negedge clk);
            if (c == 11)                 exp_sel = 3'd0;
            else if (((c - 1) % 5) < 2)  exp_sel = 3'd0;
            else                         exp_sel = 3'd1;
            if (c < 5)       exp_data = 8'h00;
            else if (c < 10) exp_data = 8'h01;
            else             exp_data = 8'h02;
            check_val("cont_sel", {29'd0, sel}, {29'd0, exp_sel});
            check_val("cont_done", {31'd0, done}, (c == 5 || c == 10) ? 32'd1 : 32'd0);
            check_val("cont_busy", {31'd0, busy}, (c <= 10) ? 32'd1 : 32'd0);
            check_val("cont_data", {24'd0, data_out}, {24'd0, exp_data});
            if (c == 5)  pat  = 8'h02;
            if (c == 10) cont = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
